energy_mode_scheduler: RTL and testbench

Sequences the vehicle energy datapath between idle, electric, hybrid, combustion-only and regenerative-braking modes.
- Arbitrates the driver/pedal request lines by fixed priority.
- Enforces a minimum dwell time per mode to prevent mode chatter.
- Tracks battery state-of-charge (SoC) with a low-battery hysteresis flag.
- Sits between pedal/brake conditioning and the powertrain mode outputs; drives the operating-mode lines of the energy system.

---
 rtl/energy_mode_scheduler.sv | 140 ++++++++++++++
 tb/tb_energy_mode_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_mode_scheduler.sv
// energy_mode_scheduler: picks the powertrain operating mode from pedal/brake requests.
// A fixed-priority request is applied at most once per dwell window, except for preempting
// requests (braking into regen, low battery forcing combustion).
// Optional feature macro: SOC_MODEL_EN -- when defined, an internal state-of-charge model
// drives soc/low_battery/regen_allowed; otherwise they follow the external battery_ok flag.
module energy_mode_scheduler #(
   parameter int unsigned MIN_DWELL  = 8,
   parameter int unsigned SOC_W      = 8,
   parameter int unsigned SOC_INIT   = 200,
   parameter int unsigned SOC_LOW    = 64,
   parameter int unsigned SOC_HYST   = 16,
   parameter int unsigned REGEN_STEP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_idle,
   input  logic             p_demand_low,
   input  logic             p_demand_high,
   input  logic             is_braking,
   input  logic             battery_ok,
   output logic [2:0]       mode,
   output logic             mode_change,
   output logic             dwell_active,
   output logic             low_battery,
   output logic [SOC_W-1:0] soc
);

   localparam int unsigned DwellW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
   localparam logic [DwellW-1:0] DwellLoad = DwellW'(MIN_DWELL - 1);
   localparam logic [SOC_W-1:0]  SocRst    = SOC_W'(SOC_INIT);
   localparam logic              LowRst    = (SOC_INIT <= SOC_LOW);

   typedef enum logic [2:0] {
      ModeIdle   = 3'b000,
      ModeElec   = 3'b001,
      ModeHybrid = 3'b010,
      ModeComb   = 3'b011,
      ModeRegen  = 3'b100
   } mode_e;

   mode_e             r_mode, w_mode_d, w_req;
   logic              r_mode_change, w_mode_change_d;
   logic [DwellW-1:0] r_dwell, w_dwell_d;
   logic              r_low, w_low_d;
   logic [SOC_W-1:0]  r_soc, w_soc_d;
   logic              w_regen_ok;
   logic              w_preempt;

   // Fixed-priority request arbitration; first match wins.
   always_comb begin
      w_req = ModeIdle;
      if (is_braking && w_regen_ok) begin
         w_req = ModeRegen;
      end else if (p_demand_high) begin
         w_req = r_low ? ModeComb : ModeHybrid;
      end else if (p_demand_low) begin
         w_req = r_low ? ModeComb : ModeElec;
      end else if (p_idle) begin
         w_req = ModeIdle;
      end
   end

   // Mode FSM next state: change when dwell expired or the request preempts.
   always_comb begin
      w_mode_d        = r_mode;
      w_mode_change_d = 1'b0;
      w_dwell_d       = (r_dwell != '0) ? r_dwell - 1'b1 : '0;
      w_preempt       = (w_req == ModeRegen) ||
                        (r_low && ((r_mode == ModeElec) || (r_mode == ModeHybrid)) &&
                         (w_req == ModeComb));
      if ((w_req != r_mode) && ((r_dwell == '0) || w_preempt)) begin
         w_mode_d        = w_req;
         w_mode_change_d = 1'b1;
         w_dwell_d       = DwellLoad;
      end
   end

`ifdef SOC_MODEL_EN
   logic [SOC_W:0] w_regen_sum;
   logic           w_unused_battery_ok;

   assign w_unused_battery_ok = battery_ok;

   // SoC model: charge in regen, drain in electric/hybrid, all saturating; hysteretic flag.
   always_comb begin
      w_soc_d     = r_soc;
      w_low_d     = r_low;
      w_regen_sum = {1'b0, r_soc} + (SOC_W + 1)'(REGEN_STEP);
      unique case (r_mode)
         ModeRegen:  w_soc_d = w_regen_sum[SOC_W] ? '1 : w_regen_sum[SOC_W-1:0];
         ModeElec:   w_soc_d = (r_soc >= SOC_W'(2)) ? r_soc - SOC_W'(2) : '0;
         ModeHybrid: w_soc_d = (r_soc != '0) ? r_soc - 1'b1 : '0;
         default:    w_soc_d = r_soc;
      endcase
      if (32'(w_soc_d) <= SOC_LOW) begin
         w_low_d = 1'b1;
      end else if (32'(w_soc_d) >= SOC_LOW + SOC_HYST) begin
         w_low_d = 1'b0;
      end
   end

   assign w_regen_ok = (r_soc != '1);
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^{REGEN_STEP, SOC_HYST};

   // Without the SoC model the battery state is just the registered external flag.
   always_comb begin
      w_soc_d = {SOC_W{battery_ok}};
      w_low_d = ~battery_ok;
   end

   assign w_regen_ok = 1'b1;
`endif

   // State register for mode, dwell and battery tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode        <= ModeIdle;
         r_mode_change <= 1'b0;
         r_dwell       <= '0;
         r_low         <= LowRst;
         r_soc         <= SocRst;
      end else begin
         r_mode        <= w_mode_d;
         r_mode_change <= w_mode_change_d;
         r_dwell       <= w_dwell_d;
         r_low         <= w_low_d;
         r_soc         <= w_soc_d;
      end
   end

   assign mode         = r_mode;
   assign mode_change  = r_mode_change;
   assign dwell_active = (r_dwell != '0);
   assign low_battery  = r_low;
   assign soc          = r_soc;

endmodule

// File: tb/tb_energy_mode_scheduler.sv
// Scoreboard bench for energy_mode_scheduler: a behavioural model pushes the expected
// post-edge state for every driven vector; it is popped and compared after the edge.
// Directed scenarios add fixed-timing checks. Honours SOC_MODEL_EN like the design.
module tb_energy_mode_scheduler;

   localparam int unsigned MIN_DWELL  = 8;
   localparam int unsigned SOC_W      = 8;
   localparam int unsigned SOC_INIT   = 200;
   localparam int unsigned SOC_LOW    = 64;
   localparam int unsigned SOC_HYST   = 16;
   localparam int unsigned REGEN_STEP = 2;
   localparam int          SOC_MAX    = 255;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             p_idle = 1'b0;
   logic             p_demand_low = 1'b0;
   logic             p_demand_high = 1'b0;
   logic             is_braking = 1'b0;
   logic             battery_ok = 1'b1;
   logic [2:0]       mode;
   logic             mode_change;
   logic             dwell_active;
   logic             low_battery;
   logic [SOC_W-1:0] soc;

   energy_mode_scheduler #(
      .MIN_DWELL  (MIN_DWELL),
      .SOC_W      (SOC_W),
      .SOC_INIT   (SOC_INIT),
      .SOC_LOW    (SOC_LOW),
      .SOC_HYST   (SOC_HYST),
      .REGEN_STEP (REGEN_STEP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .p_idle        (p_idle),
      .p_demand_low  (p_demand_low),
      .p_demand_high (p_demand_high),
      .is_braking    (is_braking),
      .battery_ok    (battery_ok),
      .mode          (mode),
      .mode_change   (mode_change),
      .dwell_active  (dwell_active),
      .low_battery   (low_battery),
      .soc           (soc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       mode;
      logic             mc;
      logic             dwell;
      logic             low;
      logic [SOC_W-1:0] soc;
   } exp_t;

   exp_t q_exp[$];
   int   n_vec = 0;
   int   n_err = 0;

   int m_mode;
   int m_dwell;
   int m_soc;
   bit m_low;
   bit m_mc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_dwell = 0;
      m_mc    = 1'b0;
      m_soc   = SOC_INIT;
      m_low   = (SOC_INIT <= SOC_LOW);
   endtask

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_step();
      int req;
      int nsoc;
      bit rok;
      bit nlow;
      bit pre;
      bit chg;
`ifdef SOC_MODEL_EN
      rok = (m_soc != SOC_MAX);
      case (m_mode)
         4:       nsoc = (m_soc + REGEN_STEP > SOC_MAX) ? SOC_MAX : m_soc + REGEN_STEP;
         1:       nsoc = (m_soc < 2) ? 0 : m_soc - 2;
         2:       nsoc = (m_soc < 1) ? 0 : m_soc - 1;
         default: nsoc = m_soc;
      endcase
      if (nsoc <= SOC_LOW) nlow = 1'b1;
      else if (nsoc >= SOC_LOW + SOC_HYST) nlow = 1'b0;
      else nlow = m_low;
`else
      rok  = 1'b1;
      nsoc = battery_ok ? SOC_MAX : 0;
      nlow = !battery_ok;
`endif
      if (is_braking && rok) req = 4;
      else if (p_demand_high) req = m_low ? 3 : 2;
      else if (p_demand_low) req = m_low ? 3 : 1;
      else req = 0;
      pre = (req == 4) || (m_low && (m_mode == 1 || m_mode == 2) && req == 3);
      chg = (req != m_mode) && (m_dwell == 0 || pre);
      m_mc    = chg;
      m_dwell = chg ? MIN_DWELL - 1 : ((m_dwell > 0) ? m_dwell - 1 : 0);
      if (chg) m_mode = req;
      m_soc = nsoc;
      m_low = nlow;
   endtask

   // Drive one vector, predict, clock, then pop and compare the DUT state.
   task automatic cycle(input bit idl, input bit lo, input bit hi, input bit brk);
      exp_t e;
      p_idle        = idl;
      p_demand_low  = lo;
      p_demand_high = hi;
      is_braking    = brk;
      model_step();
      e.mode  = 3'(m_mode);
      e.mc    = m_mc;
      e.dwell = (m_dwell != 0);
      e.low   = m_low;
      e.soc   = SOC_W'(m_soc);
      q_exp.push_back(e);
      @(posedge clk);
      #1;
      e = q_exp.pop_front();
      check_val("mode", 32'(mode), 32'(e.mode));
      check_val("mode_change", 32'(mode_change), 32'(e.mc));
      check_val("dwell_active", 32'(dwell_active), 32'(e.dwell));
      check_val("low_battery", 32'(low_battery), 32'(e.low));
      check_val("soc", 32'(soc), 32'(e.soc));
   endtask

   task automatic do_reset();
      p_idle        = 1'b0;
      p_demand_low  = 1'b0;
      p_demand_high = 1'b0;
      is_braking    = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int k;
      int pulses;

      // Reset values.
      model_reset();
      @(posedge clk);
      #1;
      check_val("rst_mode", 32'(mode), 32'd0);
      check_val("rst_mode_change", 32'(mode_change), 32'd0);
      check_val("rst_dwell", 32'(dwell_active), 32'd0);
      check_val("rst_soc", 32'(soc), 32'(SOC_INIT));
      check_val("rst_low", 32'(low_battery), 32'd0);
      reset = 1'b0;

      // Demand low: ELECTRIC after one edge, dwell active for seven cycles.
      cycle(0, 1, 0, 0);
      check_val("elec_entry_mode", 32'(mode), 32'd1);
      check_val("elec_entry_pulse", 32'(mode_change), 32'd1);
      cnt = int'(dwell_active);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 0, 0);
         cnt += int'(dwell_active);
      end
      check_val("dwell_cycles", 32'(cnt), 32'd7);

      // Demand high two cycles after ELECTRIC entry: HYBRID at the 8th edge, one pulse.
      do_reset();
      cycle(0, 1, 0, 0);
      k = 0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 2) cycle(0, 1, 0, 0);
         else cycle(0, 0, 1, 0);
         k++;
         pulses += int'(mode_change);
         if (mode == 3'd2) break;
      end
      check_val("hybrid_edges", 32'(k), 32'd8);
      check_val("hybrid_pulses", 32'(pulses), 32'd1);

      // Braking preempts HYBRID dwell; HYBRID returns only after REGEN dwell.
      cycle(0, 0, 1, 0);
      check_val("hyb_dwelling", 32'(dwell_active), 32'd1);
      cycle(0, 0, 1, 1);
      check_val("regen_preempt", 32'(mode), 32'd4);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 1, 0);
         k++;
         if (mode == 3'd2) break;
      end
      check_val("regen_exit_edges", 32'(k), 32'd8);

`ifndef SOC_MODEL_EN
      // Battery flag drop while dwelling in HYBRID forces COMBUSTION.
      battery_ok = 1'b0;
      cycle(0, 0, 1, 0);
      check_val("low_latched", 32'(low_battery), 32'd1);
      check_val("soc_follows_flag", 32'(soc), 32'd0);
      cycle(0, 0, 1, 0);
      check_val("comb_preempt", 32'(mode), 32'd3);
      check_val("comb_dwell", 32'(dwell_active), 32'd1);
      battery_ok = 1'b1;
      cycle(0, 0, 1, 0);
      check_val("soc_full", 32'(soc), 32'(SOC_MAX));
`else
      // Regen charges to saturation, after which braking no longer selects REGEN.
      do_reset();
      for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1);
      check_val("soc_saturated", 32'(soc), 32'(SOC_MAX));
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 0, 1);
         if (mode == 3'd0) break;
      end
      check_val("regen_disallowed", 32'(mode), 32'd0);

      // Electric drains to the low threshold, then COMBUSTION preempts the dwell.
      do_reset();
      cycle(0, 1, 0, 0);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(0, 1, 0, 0);
         k++;
         if (mode == 3'd3) break;
      end
      check_val("drain_edges", 32'(k), 32'd69);
      check_val("drain_low", 32'(low_battery), 32'd1);
      for (int i = 0; i < 40; i++) begin
         cycle(0, 0, 0, 1);
         if (low_battery == 1'b0) break;
      end
      check_val("low_cleared", 32'(low_battery), 32'd0);
      for (int i = 0; i < 20; i++) begin
         cycle(0, 1, 0, 0);
         if (mode == 3'd1) break;
      end
      check_val("back_to_elec", 32'(mode), 32'd1);
`endif

      // Random request mix against the model.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) battery_ok = ~battery_ok;
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      end
      battery_ok = 1'b1;

      // Asynchronous reset mid-REGEN while dwelling.
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      check_val("mid_regen_mode", 32'(mode), 32'd4);
      check_val("mid_regen_dwell", 32'(dwell_active), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check_val("async_mode", 32'(mode), 32'd0);
      check_val("async_mode_change", 32'(mode_change), 32'd0);
      check_val("async_dwell", 32'(dwell_active), 32'd0);
      check_val("async_soc", 32'(soc), 32'(SOC_INIT));
      check_val("async_low", 32'(low_battery), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle(0, 1, 0, 0);
      check_val("post_reset_entry", 32'(mode), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
